// File: rtl/lcd_text_display_if.sv
// LCD pin bundle for a 4-bit, write-only HD44780 connection.
interface lcd_text_display_if;
  logic lcd_rs;
  logic lcd_rw;
  logic lcd_e;
  logic lcd_4;
  logic lcd_5;
  logic lcd_6;
  logic lcd_7;

  modport master (output lcd_rs, lcd_rw, lcd_e, lcd_4, lcd_5, lcd_6, lcd_7);
  modport slave  (input  lcd_rs, lcd_rw, lcd_e, lcd_4, lcd_5, lcd_6, lcd_7);
endinterface

// File: rtl/lcd_text_display.sv
// 16x2 HD44780 text driver: power-up wait, 4-bit init, then endless refresh of
// both lines from the 256-bit `chars` register. All timing advances on `tick`.
// Optional feature macro: LCD_SCROLL_EN (rotate line 1 left once per refresh pass).
module lcd_text_display #(
  parameter int unsigned POWERUP_TICKS    = 20000,
  parameter int unsigned CMD_WAIT_TICKS   = 50,
  parameter int unsigned CLEAR_WAIT_TICKS = 2000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  lcd_text_display_if.master  bus
);

  localparam int unsigned MAX_A    = (POWERUP_TICKS > CMD_WAIT_TICKS) ? POWERUP_TICKS : CMD_WAIT_TICKS;
  localparam int unsigned MAX_WAIT = (MAX_A > CLEAR_WAIT_TICKS) ? MAX_A : CLEAR_WAIT_TICKS;
  localparam int unsigned CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [255:0] CHARS_DEFAULT = {"LCD HIEN THI TEN", "  NAME DISPLAY  "};

  typedef enum logic [2:0] {
    POWERUP, INIT, LINE1_ADDR, LINE1_DATA, LINE2_ADDR, LINE2_DATA
  } state_t;

  typedef enum logic [2:0] {
    PH_SETUP, PH_E_HI, PH_E_HOLD, PH_E_LO, PH_WAIT
  } phase_t;

  state_t             state_q, state_d;
  phase_t             ph_q, ph_d;
  logic [2:0]         step_q, step_d;
  logic [3:0]         idx_q, idx_d;
  logic               lo_q, lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [255:0]       chars, chars_d;
  logic               rs_q, rs_d;
  logic               e_q, e_d;
  logic [3:0]         nib_q, nib_d;
  logic               adv;
  logic [CNT_W-1:0]   wait_last;
  logic [8:0]         next_item;

  // {rs, byte} for the item selected by state / init step / char index
  function automatic logic [8:0] item(input state_t st, input logic [2:0] stp,
                                      input logic [3:0] idx, input logic [255:0] ch);
    logic [127:0] line;
    item = 9'h000;
    line = '0;
    case (st)
      INIT: begin
        case (stp)
          3'd0, 3'd1, 3'd2: item = 9'h003;
          3'd3:             item = 9'h002;
          3'd4:             item = 9'h028;
          3'd5:             item = 9'h00C;
          3'd6:             item = 9'h006;
          default:          item = 9'h001;
        endcase
      end
      LINE1_ADDR: item = 9'h080;
      LINE1_DATA: begin
        line = ch[255:128] << {idx, 3'b000};
        item = {1'b1, line[127:120]};
      end
      LINE2_ADDR: item = 9'h0C0;
      LINE2_DATA: begin
        line = ch[127:0] << {idx, 3'b000};
        item = {1'b1, line[127:120]};
      end
      default: item = 9'h000;
    endcase
  endfunction

  // Clear command needs the long wait; everything else the short one
  assign wait_last = (state_q == INIT && step_q == 3'd7) ? CNT_W'(CLEAR_WAIT_TICKS - 1)
                                                         : CNT_W'(CMD_WAIT_TICKS - 1);

  // State and pin registers; everything holds unless tick is high
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= POWERUP;
      ph_q    <= PH_SETUP;
      step_q  <= '0;
      idx_q   <= '0;
      lo_q    <= 1'b0;
      cnt_q   <= '0;
      chars   <= CHARS_DEFAULT;
      rs_q    <= 1'b0;
      e_q     <= 1'b0;
      nib_q   <= '0;
    end else if (tick) begin
      state_q <= state_d;
      ph_q    <= ph_d;
      step_q  <= step_d;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      chars   <= chars_d;
      rs_q    <= rs_d;
      e_q     <= e_d;
      nib_q   <= nib_d;
    end
  end

  // Next step: sequence nibble phases, waits and item/line progression
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    step_d  = step_q;
    idx_d   = idx_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    chars_d = chars;
    adv     = 1'b0;

    if (state_q == POWERUP) begin
      if (cnt_q == CNT_W'(POWERUP_TICKS - 1)) begin
        state_d = INIT;
        step_d  = '0;
        cnt_d   = '0;
        adv     = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      case (ph_q)
        PH_SETUP:  ph_d = PH_E_HI;
        PH_E_HI:   ph_d = PH_E_HOLD;
        PH_E_HOLD: ph_d = PH_E_LO;
        PH_E_LO: begin
          if (!lo_q) begin
            ph_d = PH_SETUP;
            lo_d = 1'b1;
          end else begin
            ph_d  = PH_WAIT;
            cnt_d = '0;
          end
        end
        PH_WAIT: begin
          if (cnt_q == wait_last) begin
            cnt_d = '0;
            adv   = 1'b1;
            case (state_q)
              INIT: begin
                if (step_q == 3'd7) state_d = LINE1_ADDR;
                else                step_d  = step_q + 3'd1;
              end
              LINE1_ADDR: begin
                state_d = LINE1_DATA;
                idx_d   = '0;
              end
              LINE1_DATA: begin
                if (idx_q == 4'd15) begin
                  state_d = LINE2_ADDR;
                  idx_d   = '0;
                end else begin
                  idx_d = idx_q + 4'd1;
                end
              end
              LINE2_ADDR: begin
                state_d = LINE2_DATA;
                idx_d   = '0;
              end
              LINE2_DATA: begin
                if (idx_q == 4'd15) begin
                  state_d = LINE1_ADDR;
                  idx_d   = '0;
`ifdef LCD_SCROLL_EN
                  chars_d[255:128] = {chars[247:128], chars[255:248]};
`endif
                end else begin
                  idx_d = idx_q + 4'd1;
                end
              end
              default: state_d = POWERUP;
            endcase
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: ph_d = PH_SETUP;
      endcase
    end

    // New item: init nibbles 0..3 are single low-nibble transfers
    if (adv) begin
      ph_d = PH_SETUP;
      lo_d = (state_d == INIT) && !step_d[2];
    end

    next_item = item(state_d, step_d, idx_d, chars_d);
    rs_d  = next_item[8];
    nib_d = lo_d ? next_item[3:0] : next_item[7:4];
    e_d   = (state_d != POWERUP) && (ph_d == PH_E_HI || ph_d == PH_E_HOLD);
  end

  assign bus.lcd_rs = rs_q;
  assign bus.lcd_rw = 1'b0;
  assign bus.lcd_e  = e_q;
  assign bus.lcd_4  = nib_q[0];
  assign bus.lcd_5  = nib_q[1];
  assign bus.lcd_6  = nib_q[2];
  assign bus.lcd_7  = nib_q[3];

endmodule

// File: tb/tb_lcd_text_display.sv
// Bench for lcd_text_display: random tick stream, nibble stream and step timing
// checked against a list-based model of the init/refresh protocol.
module tb_lcd_text_display;

  localparam int unsigned PU  = 4;
  localparam int unsigned CW  = 2;
  localparam int unsigned CLW = 3;
  localparam int NPASS  = 17;
  localparam int TARGET = 12 + 68 * 16 + 2;

  logic clk = 1'b0;
  logic rst_n;
  logic tick;

  lcd_text_display_if bus ();

  lcd_text_display #(
    .POWERUP_TICKS    (PU),
    .CMD_WAIT_TICKS   (CW),
    .CLEAR_WAIT_TICKS (CLW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input bit ok, input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: flat list of expected nibbles with step gaps
  int    exp_rs[$];
  int    exp_nib[$];
  int    exp_gap[$];
  int    gap_next;
  string L1 = "LCD HIEN THI TEN";
  string L2 = "  NAME DISPLAY  ";

  function automatic logic [127:0] line_vec(input string s, input int r);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[127 - 8 * i -: 8] = s[(i + r) % 16];
    return v;
  endfunction

  task automatic push_item(input int rs, input int b, input bit single, input int w);
    if (!single) begin
      exp_rs.push_back(rs); exp_nib.push_back(b / 16); exp_gap.push_back(gap_next);
      gap_next = 4;
    end
    exp_rs.push_back(rs); exp_nib.push_back(b % 16); exp_gap.push_back(gap_next);
    gap_next = w + 4;
  endtask

  function automatic int rot_for_pass(input int p);
`ifdef LCD_SCROLL_EN
    return p % 16;
`else
    return 0 * p;
`endif
  endfunction

  task automatic build_model();
    int r;
    logic [127:0] v1, v2;
    gap_next = PU + 3;
    push_item(0, 3, 1, CW); push_item(0, 3, 1, CW);
    push_item(0, 3, 1, CW); push_item(0, 2, 1, CW);
    push_item(0, 8'h28, 0, CW); push_item(0, 8'h0C, 0, CW);
    push_item(0, 8'h06, 0, CW); push_item(0, 8'h01, 0, CLW);
    for (int p = 0; p < NPASS; p++) begin
      r  = rot_for_pass(p);
      v1 = line_vec(L1, r);
      v2 = line_vec(L2, 0);
      push_item(0, 8'h80, 0, CW);
      for (int i = 0; i < 16; i++) push_item(1, int'(v1[127 - 8 * i -: 8]), 0, CW);
      push_item(0, 8'hC0, 0, CW);
      for (int i = 0; i < 16; i++) push_item(1, int'(v2[127 - 8 * i -: 8]), 0, CW);
    end
  endtask

  // Compare process: runs every cycle on the falling clock edge
  int         k = 0;
  int         steps = 0;
  bit         pend_rst = 1'b1;
  bit         pend_step = 1'b0;
  logic       prev_rs = 1'b0, prev_e = 1'b0;
  logic [3:0] prev_nib = '0;
  logic [3:0] mon_nib;
  int         obs[64];

  always @(negedge clk) begin
    mon_nib = {bus.lcd_7, bus.lcd_6, bus.lcd_5, bus.lcd_4};
    if (pend_rst) begin
      check({bus.lcd_rs, bus.lcd_rw, bus.lcd_e, mon_nib} == 7'b0, "reset_outputs",
            256'({bus.lcd_rs, bus.lcd_rw, bus.lcd_e, mon_nib}), 256'(0));
      k = 0;
      steps = 0;
    end else begin
      if (pend_step) steps++;
      else check({bus.lcd_rs, bus.lcd_e, mon_nib} == {prev_rs, prev_e, prev_nib}, "hold_no_tick",
                 256'({bus.lcd_rs, bus.lcd_e, mon_nib}), 256'({prev_rs, prev_e, prev_nib}));
      check(bus.lcd_rw == 1'b0, "rw_zero", 256'(bus.lcd_rw), 256'(0));
      if (prev_e)
        check({bus.lcd_rs, mon_nib} == {prev_rs, prev_nib}, "stable_while_e",
              256'({bus.lcd_rs, mon_nib}), 256'({prev_rs, prev_nib}));
      if (prev_e && !bus.lcd_e) begin
        if (k < exp_nib.size()) begin
          check(int'({bus.lcd_rs, mon_nib}) == exp_rs[k] * 16 + exp_nib[k], "nibble",
                256'({bus.lcd_rs, mon_nib}), 256'(exp_rs[k] * 16 + exp_nib[k]));
          check(steps == exp_gap[k], "step_gap", 256'(steps), 256'(exp_gap[k]));
          if (k < 64) obs[k] = int'({bus.lcd_rs, mon_nib});
          if (k >= 80 && (k - 12) % 68 == 0)
            check(dut.chars == {line_vec(L1, rot_for_pass((k - 12) / 68)), line_vec(L2, 0)},
                  "chars_pass", dut.chars,
                  {line_vec(L1, rot_for_pass((k - 12) / 68)), line_vec(L2, 0)});
          if (k == 80) begin
`ifdef LCD_SCROLL_EN
            check(dut.chars[255:248] == 8'h43, "first_char_pass1", 256'(dut.chars[255:248]), 256'(8'h43));
`else
            check(dut.chars[255:248] == 8'h4C, "first_char_pass1", 256'(dut.chars[255:248]), 256'(8'h4C));
`endif
          end
        end else begin
          check(1'b0, "stream_overrun", 256'(k), 256'(exp_nib.size()));
        end
        k++;
        steps = 0;
      end
    end
    prev_rs   = bus.lcd_rs;
    prev_e    = bus.lcd_e;
    prev_nib  = mon_nib;
    pend_rst  = !rst_n;
    pend_step = tick;
  end

  // Hand-derived first nibbles: init, 0x80, 'L', 'C' as {rs, nibble}
  int lit[18] = '{3, 3, 3, 2, 2, 8, 0, 12, 0, 6, 0, 1, 8, 0, 20, 28, 20, 19};

  initial begin
    bit got_e;
    rst_n = 1'b0;
    tick  = 1'b0;
    build_model();

    // Reset with tick toggling
    repeat (3) begin
      @(posedge clk);
      #2 tick = ~tick;
    end
    @(negedge clk);
    check(dut.chars[255:248] == 8'h4C, "reset_chars_l1", 256'(dut.chars[255:248]), 256'(8'h4C));
    check(dut.chars[127:120] == 8'h20, "reset_chars_l2", 256'(dut.chars[127:120]), 256'(8'h20));

    // Tick gating: nothing moves with tick low
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    check({bus.lcd_rs, bus.lcd_e, bus.lcd_7, bus.lcd_6, bus.lcd_5, bus.lcd_4} == 6'b0, "gated_outputs",
          256'({bus.lcd_rs, bus.lcd_e}), 256'(0));
    check(dut.chars == {line_vec(L1, 0), line_vec(L2, 0)}, "gated_chars", dut.chars,
          {line_vec(L1, 0), line_vec(L2, 0)});

    // Run partway, then reset while the strobe is high
    for (int c = 0; c < 5000 && k < 20; c++) begin
      @(posedge clk);
      #2 tick = ($urandom_range(0, 3) != 0);
    end
    check(k >= 20, "early_progress", 256'(k), 256'(20));
    got_e = 1'b0;
    for (int c = 0; c < 500 && !got_e; c++) begin
      @(posedge clk);
      #2;
      if (bus.lcd_e) got_e = 1'b1;
      else tick = ($urandom_range(0, 3) != 0);
    end
    check(got_e, "e_high_seen", 256'(got_e), 256'(1));
    rst_n = 1'b0;
    tick  = ($urandom_range(0, 1) != 0);
    @(posedge clk);
    @(negedge clk);
    check(bus.lcd_e == 1'b0, "mid_reset_e", 256'(bus.lcd_e), 256'(0));
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Main random run through 16 refresh passes
    for (int c = 0; c < 80000 && k < TARGET; c++) begin
      @(posedge clk);
      #2 tick = ($urandom_range(0, 3) != 0);
    end
    check(k >= TARGET, "run_timeout", 256'(k), 256'(TARGET));
    @(negedge clk);
    for (int i = 0; i < 18; i++)
      check(obs[i] == lit[i], "literal_nibble", 256'(obs[i]), 256'(lit[i]));
    check(dut.chars[255:128] == 128'("LCD HIEN THI TEN"), "line1_after_16", 256'(dut.chars[255:128]),
          256'("LCD HIEN THI TEN"));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
